seq_shift_add_multiplier: RTL and testbench

- Sequential unsigned shift-and-add multiplier; the inverse operation to the team's array divider.
- Produces the full 2*WIDTH-bit product P = A*B over a fixed WIDTH-cycle iteration.
- Uses a start/busy/done handshake.
- Sits beside the divider in the arithmetic library and is used where area matters more than latency.

---
 rtl/seq_shift_add_multiplier_if.sv | 15 +
 rtl/seq_shift_add_multiplier.sv | 80 ++++++++
 tb/tb_seq_shift_add_multiplier.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/seq_shift_add_multiplier_if.sv
// Handshake and data bundle for the sequential shift-and-add multiplier.
// The requester drives start/A/B; the multiplier returns busy/done/P.
interface seq_shift_add_multiplier_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   P;

    modport master (output start, A, B, input busy, done, P);
    modport slave  (input start, A, B, output busy, done, P);
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// Unsigned sequential shift-and-add multiplier: one partial product per cycle,
// full 2*WIDTH-bit product after exactly WIDTH RUN cycles, start/busy/done handshake.
module seq_shift_add_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    seq_shift_add_multiplier_if.slave     bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH:0]       r_acc;
    logic [WIDTH-1:0]     r_mplr;
    logic [CW-1:0]        r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_p;

    logic [WIDTH:0]       w_addend;
    logic [WIDTH:0]       w_sum;

    // acc's top bit is always zero after a shift, so adding the full WIDTH+1
    // register keeps the carry out of the partial sum without truncation.
    assign w_addend = r_mplr[0] ? {1'b0, r_mcand} : '0;
    assign w_sum    = r_acc + w_addend;

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.P    = r_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_mcand <= '0;
            r_acc   <= '0;
            r_mplr  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_p     <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_mcand <= bus.A;
                        r_mplr  <= bus.B;
                        r_acc   <= '0;
                        r_cnt   <= CW'(WIDTH);
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_acc  <= w_sum >> 1;
                    r_mplr <= {w_sum[0], r_mplr[WIDTH-1:1]};
                    r_cnt  <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        // Product taken from the shifted values being written this cycle.
                        r_p     <= {w_sum[WIDTH:1], w_sum[0], r_mplr[WIDTH-1:1]};
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed and randomized checks of the shift-and-add multiplier at WIDTH=4 and WIDTH=8
// against plain A*B arithmetic and the fixed start-to-done latency.
module tb_seq_shift_add_multiplier;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    seq_shift_add_multiplier_if #(.WIDTH(4)) bus4 ();
    seq_shift_add_multiplier_if #(.WIDTH(8)) bus8 ();

    seq_shift_add_multiplier #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    seq_shift_add_multiplier #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge; all driving and sampling happens 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Full 4-bit transaction from IDLE/DONE: latency and product checked against a*b.
    task automatic op4(input int a, input int b, input string tag);
        bus4.start = 1'b1;
        bus4.A     = 4'(a);
        bus4.B     = 4'(b);
        tick();
        bus4.start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk({tag, "_busy"}, 32'(bus4.busy), 32'd1);
            chk({tag, "_nodone"}, 32'(bus4.done), 32'd0);
            tick();
        end
        chk({tag, "_done"}, 32'(bus4.done), 32'd1);
        chk({tag, "_idle_busy"}, 32'(bus4.busy), 32'd0);
        chk({tag, "_P"}, 32'(bus4.P), 32'(a * b));
        $display("op4 %s A=%0d B=%0d P=%0d", tag, a, b, bus4.P);
        tick();
        chk({tag, "_pulse"}, 32'(bus4.done), 32'd0);
    endtask

    task automatic op8(input int a, input int b, input string tag);
        bus8.start = 1'b1;
        bus8.A     = 8'(a);
        bus8.B     = 8'(b);
        tick();
        bus8.start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            chk({tag, "_busy"}, 32'(bus8.busy), 32'd1);
            tick();
        end
        chk({tag, "_done"}, 32'(bus8.done), 32'd1);
        chk({tag, "_P"}, 32'(bus8.P), 32'(a * b));
        $display("op8 %s A=%0d B=%0d P=%0d", tag, a, b, bus8.P);
        tick();
        chk({tag, "_pulse"}, 32'(bus8.done), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus4.start = 1'b0; bus4.A = '0; bus4.B = '0;
        bus8.start = 1'b0; bus8.A = '0; bus8.B = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst4_busy", 32'(bus4.busy), 32'd0);
        chk("rst4_done", 32'(bus4.done), 32'd0);
        chk("rst4_P", 32'(bus4.P), 32'd0);
        chk("rst8_P", 32'(bus8.P), 32'd0);
        tick();
        chk("idle4_busy", 32'(bus4.busy), 32'd0);

        op4(13, 11, "basic");
        op4(15, 15, "max");
        op4(15, 0, "b_zero");
        op4(0, 9, "a_zero");
        op4(1, 7, "a_one");

        // start held during RUN must be ignored
        bus4.start = 1'b1; bus4.A = 4'd3; bus4.B = 4'd5;
        tick();
        bus4.A = 4'd15; bus4.B = 4'd15;
        tick();
        tick();
        bus4.start = 1'b0;
        chk("ign_busy", 32'(bus4.busy), 32'd1);
        tick();
        chk("ign_busy4", 32'(bus4.busy), 32'd1);
        tick();
        chk("ign_done", 32'(bus4.done), 32'd1);
        chk("ign_P", 32'(bus4.P), 32'd15);
        $display("ignore A=3 B=5 P=%0d", bus4.P);
        tick();
        chk("ign_single_done", 32'(bus4.done), 32'd0);
        chk("ign_no_restart", 32'(bus4.busy), 32'd0);

        // back-to-back: second start accepted in the DONE cycle
        bus4.start = 1'b1; bus4.A = 4'd6; bus4.B = 4'd7;
        tick();
        bus4.start = 1'b0;
        tick(); tick(); tick();
        tick();
        chk("b2b_done1", 32'(bus4.done), 32'd1);
        chk("b2b_P1", 32'(bus4.P), 32'd42);
        $display("b2b first A=6 B=7 P=%0d", bus4.P);
        bus4.start = 1'b1; bus4.A = 4'd9; bus4.B = 4'd9;
        tick();
        bus4.start = 1'b0;
        chk("b2b_resume_busy", 32'(bus4.busy), 32'd1);
        chk("b2b_resume_done", 32'(bus4.done), 32'd0);
        chk("b2b_hold_P", 32'(bus4.P), 32'd42);
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk("b2b_busy", 32'(bus4.busy), 32'd1);
            chk("b2b_hold_P", 32'(bus4.P), 32'd42);
        end
        tick();
        chk("b2b_done2", 32'(bus4.done), 32'd1);
        chk("b2b_P2", 32'(bus4.P), 32'd81);
        $display("b2b second A=9 B=9 P=%0d", bus4.P);
        tick();

        // reset in the second RUN cycle
        bus4.start = 1'b1; bus4.A = 4'd12; bus4.B = 4'd12;
        tick();
        bus4.start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_busy", 32'(bus4.busy), 32'd0);
        chk("mrst_done", 32'(bus4.done), 32'd0);
        chk("mrst_P", 32'(bus4.P), 32'd0);
        tick(); tick(); tick();
        chk("mrst_stays_idle", 32'(bus4.done), 32'd0);
        $display("midrun reset P=%0d", bus4.P);
        op4(2, 3, "after_rst");

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                op4(a, b, "sweep4");
            end
        end

        op8(255, 255, "max8");
        op8(0, 255, "zero8");
        op8(255, 1, "one8");
        for (int i = 0; i < 120; i++) begin
            op8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), "rand8");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
